pcie_rx_avst_axis_bridge_ml: RTL and testbench
==============================================

Name: pcie_rx_avst_axis_bridge_ml

Overview:
Parametrised successor to the PCIe AVST-to-AXI4-S RX bridge. It accepts multi-channel Avalon-ST RX beats from the PCIe hard IP with a configurable ready latency and buffers them in an internal FIFO so that no in-flight beat is ever lost. It presents the beats on an AXI4-S RX master port, optionally compacting valid channels to the lowest indices. It flags overflow and SOP/EOP protocol errors, and sits between the PCIe IP RX port and the FIM RX AXI-S fabric.

Parameters:
NUM_CH, 2, number of TLP channels per beat (1..4)
DATA_W, 256, payload bits per channel
HDR_W, 128, header bits per channel
READY_LATENCY, 3, cycles from avl_rx_ready change to source honouring it (0..31)
DEPTH, 16, FIFO entries; must be a power of 2 and >= READY_LATENCY+4 (elaboration error otherwise)
COMPACT, 0, 1 = pack valid channels to lowest indices on write

Ports:
avl_clk  in  1  sole clock
avl_rst  in  1  synchronous, active-high reset
avl_rx_valid  in  NUM_CH  per-channel beat valid
avl_rx_sop  in  NUM_CH  per-channel start of packet
avl_rx_eop  in  NUM_CH  per-channel end of packet
avl_rx_hdr  in  NUM_CH*HDR_W  per-channel header; ch i at [i*HDR_W +: HDR_W]
avl_rx_data  in  NUM_CH*DATA_W  per-channel payload
avl_rx_ready  out  1  registered ready to source
axis_rx_tvalid  out  1  AXI-S valid
axis_rx_tready  in  1  AXI-S ready
axis_rx_valid  out  NUM_CH  per-channel valid of presented beat
axis_rx_sop  out  NUM_CH  per-channel sop
axis_rx_eop  out  NUM_CH  per-channel eop
axis_rx_hdr  out  NUM_CH*HDR_W  headers
axis_rx_data  out  NUM_CH*DATA_W  payloads
fifo_level  out  $clog2(DEPTH)+1  current occupancy
overflow_err  out  1  sticky: beat dropped
proto_err  out  1  sticky: SOP/EOP sequencing violation

Behaviour:
- Reset, while avl_rst=1: FIFO empty, fifo_level=0, avl_rx_ready=0, axis_rx_tvalid=0, axis_rx_valid/sop/eop=0, both error flags=0, per-channel packet-open state cleared. A reset asserted mid-operation discards all buffered beats; inputs are ignored during reset.
- Write: a beat is captured when |avl_rx_valid is true. avl_rx_ready is not qualified; the source owns ready-latency compliance. All-invalid beats are not written.
- Write when full:
  - If count==DEPTH and there is no read this cycle, the beat is dropped and overflow_err is set.
  - A simultaneous read and write at full succeeds, and count is unchanged.
- Ready generation: avl_rx_ready <= (DEPTH - count_next) > READY_LATENCY+1, where count_next is the occupancy after this cycle's read and write. This leaves headroom for READY_LATENCY+1 post-deassert beats.
- Compaction:
  - COMPACT=1: the k-th set bit of avl_rx_valid (LSB first) is stored in channel slot k, and higher slots store valid=0.
  - COMPACT=0: channels are stored positionally.
  - In both modes, the hdr, data, sop and eop fields of invalid slots are stored as zero.
- Read:
  - FIFO head is shown first-word-fall-through from a registered output stage.
  - A beat written in cycle T is visible at axis_rx_tvalid in T+1 when the FIFO was empty.
  - A beat pops on tvalid&&tready.
  - While tvalid=1 and tready=0, all axis_rx_* outputs hold stable.
- Pointers: log2(DEPTH) bits, wrapping modulo DEPTH. fifo_level counts 0..DEPTH.
- Protocol check, per input channel on valid beats, before compaction:
  - Set proto_err on any of these: sop while the packet is open and not eop in the same beat; non-sop beat while the packet is closed.
  - sop&&eop is a single-beat packet.
  - The open state updates regardless of errors: sop opens the packet, and eop closes it.
  - Dropped beats still update the open state.
- Error flags are sticky until reset.
- No combinational path from axis_rx_tready to avl_rx_ready is permitted.

Test Plan:
1. NUM_CH=2, DEPTH=8, RL=3. After reset, ready=1 at the first cycle after avl_rst falls. Write 1 beat with ch0 hdr=0xA5 at T -> axis_rx_tvalid=1 at T+1 with hdr0=0xA5, and fifo_level=1.
2. Hold tready=0 and stream valid beats every cycle -> ready falls on the cycle after count_next reaches 4. The 4 further in-flight beats are accepted, giving fifo_level=8, and overflow_err stays 0.
3. Full FIFO, tready=0, one extra beat -> beat dropped, overflow_err=1, fifo_level stays 8. Then tready=1 -> exactly 8 beats drain in order.
4. COMPACT=1, valid=2'b10 with ch1 hdr=0x3C -> output valid=2'b01, hdr0=0x3C, hdr1=0.
5. ch0 sequence sop, then sop (no eop) -> proto_err=1 at the cycle after the second beat. An eop-only beat on an idle ch1 -> proto_err stays 1 until reset.
6. Assert avl_rst with 5 beats buffered -> next cycle tvalid=0, fifo_level=0, errors=0. After release, a new beat is seen with none of the old data.

Source files
------------

// File: rtl/pcie_rx_avst_axis_bridge_ml.sv
// PCIe RX bridge: multi-channel Avalon-ST beats buffered in a FIFO and replayed on AXI4-S.
// Ready is derived from post-update occupancy so READY_LATENCY+1 in-flight beats always fit.
module pcie_rx_avst_axis_bridge_ml #(
  parameter int NUM_CH        = 2,
  parameter int DATA_W        = 256,
  parameter int HDR_W         = 128,
  parameter int READY_LATENCY = 3,
  parameter int DEPTH         = 16,
  parameter int COMPACT       = 0
) (
  input  logic                       avl_clk,
  input  logic                       avl_rst,
  input  logic [NUM_CH-1:0]          avl_rx_valid,
  input  logic [NUM_CH-1:0]          avl_rx_sop,
  input  logic [NUM_CH-1:0]          avl_rx_eop,
  input  logic [NUM_CH*HDR_W-1:0]    avl_rx_hdr,
  input  logic [NUM_CH*DATA_W-1:0]   avl_rx_data,
  output logic                       avl_rx_ready,
  output logic                       axis_rx_tvalid,
  input  logic                       axis_rx_tready,
  output logic [NUM_CH-1:0]          axis_rx_valid,
  output logic [NUM_CH-1:0]          axis_rx_sop,
  output logic [NUM_CH-1:0]          axis_rx_eop,
  output logic [NUM_CH*HDR_W-1:0]    axis_rx_hdr,
  output logic [NUM_CH*DATA_W-1:0]   axis_rx_data,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow_err,
  output logic                       proto_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < READY_LATENCY + 4) ||
      (NUM_CH < 1) || (NUM_CH > 4)) begin : g_bad_param
    $error("pcie_rx_avst_axis_bridge_ml: illegal DEPTH/READY_LATENCY/NUM_CH combination");
  end

  typedef struct packed {
    logic [NUM_CH-1:0]        valid;
    logic [NUM_CH-1:0]        sop;
    logic [NUM_CH-1:0]        eop;
    logic [NUM_CH*HDR_W-1:0]  hdr;
    logic [NUM_CH*DATA_W-1:0] data;
  } beat_t;

  beat_t             mem_r [DEPTH];
  beat_t             in_beat_s;
  beat_t             out_r;
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW-1:0]     rd_ptr_next_s;
  logic [CW-1:0]     count_r;
  logic [CW-1:0]     count_next_s;
  logic [NUM_CH-1:0] open_r;
  logic [NUM_CH-1:0] open_next_s;
  logic              wr_s;
  logic              rd_s;
  logic              full_s;
  logic              wr_ok_s;
  logic              head_from_in_s;
  logic              ready_next_s;
  logic              proto_hit_s;

  // Build the stored beat: route each valid channel to its slot, zero every invalid slot.
  always_comb begin
    int rank;
    int tgt;
    logic hit;
    in_beat_s = '0;
    rank      = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      tgt = (COMPACT != 0) ? rank : i;
      for (int j = 0; j < NUM_CH; j++) begin
        hit = avl_rx_valid[i] && (tgt == j);
        in_beat_s.valid[j] = in_beat_s.valid[j] | hit;
        in_beat_s.sop[j]   = in_beat_s.sop[j] | (hit & avl_rx_sop[i]);
        in_beat_s.eop[j]   = in_beat_s.eop[j] | (hit & avl_rx_eop[i]);
        in_beat_s.hdr[j*HDR_W +: HDR_W] = in_beat_s.hdr[j*HDR_W +: HDR_W] |
                                          (avl_rx_hdr[i*HDR_W +: HDR_W] & {HDR_W{hit}});
        in_beat_s.data[j*DATA_W +: DATA_W] = in_beat_s.data[j*DATA_W +: DATA_W] |
                                             (avl_rx_data[i*DATA_W +: DATA_W] & {DATA_W{hit}});
      end
      rank = rank + int'(avl_rx_valid[i]);
    end
  end

  // Occupancy bookkeeping; a write at full only lands when the head pops in the same cycle.
  always_comb begin
    wr_s           = |avl_rx_valid;
    rd_s           = axis_rx_tvalid && axis_rx_tready;
    full_s         = (count_r == CW'(DEPTH));
    wr_ok_s        = wr_s && (!full_s || rd_s);
    count_next_s   = count_r + CW'(wr_ok_s) - CW'(rd_s);
    rd_ptr_next_s  = rd_ptr_r + AW'(rd_s);
    head_from_in_s = wr_ok_s && (count_r == CW'(rd_s));
    ready_next_s   = (DEPTH - int'(count_next_s)) > (READY_LATENCY + 1);
  end

  // Per-channel SOP/EOP sequencing on raw input channels; open state follows even dropped beats.
  always_comb begin
    proto_hit_s = 1'b0;
    open_next_s = open_r;
    for (int i = 0; i < NUM_CH; i++) begin
      proto_hit_s = proto_hit_s |
                    (avl_rx_valid[i] & ((avl_rx_sop[i] & open_r[i] & ~avl_rx_eop[i]) |
                                        (~avl_rx_sop[i] & ~open_r[i])));
      if (avl_rx_valid[i]) begin
        open_next_s[i] = avl_rx_eop[i] ? 1'b0 : (avl_rx_sop[i] ? 1'b1 : open_r[i]);
      end else begin
        open_next_s[i] = open_r[i];
      end
    end
  end

  // Storage array; contents are don't-care until pointed at by a valid occupancy.
  always_ff @(posedge avl_clk) begin
    if (!avl_rst && wr_ok_s) begin
      mem_r[wr_ptr_r] <= in_beat_s;
    end
  end

  // Pointers, flags and the registered FWFT output stage.
  always_ff @(posedge avl_clk) begin
    if (avl_rst) begin
      wr_ptr_r       <= '0;
      rd_ptr_r       <= '0;
      count_r        <= '0;
      avl_rx_ready   <= 1'b0;
      axis_rx_tvalid <= 1'b0;
      out_r          <= '0;
      overflow_err   <= 1'b0;
      proto_err      <= 1'b0;
      open_r         <= '0;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      rd_ptr_r       <= rd_ptr_next_s;
      count_r        <= count_next_s;
      avl_rx_ready   <= ready_next_s;
      axis_rx_tvalid <= (count_next_s != '0);
      // The new head is either the beat arriving now (FIFO drains to empty) or the stored entry.
      if (count_next_s == '0) begin
        out_r <= '0;
      end else if (head_from_in_s) begin
        out_r <= in_beat_s;
      end else begin
        out_r <= mem_r[rd_ptr_next_s];
      end
      overflow_err <= overflow_err | (wr_s && full_s && !rd_s);
      proto_err    <= proto_err | proto_hit_s;
      open_r       <= open_next_s;
    end
  end

  assign axis_rx_valid = out_r.valid;
  assign axis_rx_sop   = out_r.sop;
  assign axis_rx_eop   = out_r.eop;
  assign axis_rx_hdr   = out_r.hdr;
  assign axis_rx_data  = out_r.data;
  assign fifo_level    = count_r;

endmodule

// File: tb/tb_pcie_rx_avst_axis_bridge_ml.sv
// Scoreboard bench for pcie_rx_avst_axis_bridge_ml: 2 channels, DEPTH 8, READY_LATENCY 3, compaction on.
module tb_pcie_rx_avst_axis_bridge_ml;

  localparam int NUM_CH = 2;
  localparam int DATA_W = 32;
  localparam int HDR_W  = 16;

  typedef struct packed {
    logic [1:0]  v;
    logic [1:0]  s;
    logic [1:0]  e;
    logic [31:0] h;
    logic [63:0] d;
  } beat_t;

  logic                     clk;
  logic                     rst;
  logic [NUM_CH-1:0]        avl_rx_valid;
  logic [NUM_CH-1:0]        avl_rx_sop;
  logic [NUM_CH-1:0]        avl_rx_eop;
  logic [NUM_CH*HDR_W-1:0]  avl_rx_hdr;
  logic [NUM_CH*DATA_W-1:0] avl_rx_data;
  logic                     avl_rx_ready;
  logic                     axis_rx_tvalid;
  logic                     axis_rx_tready;
  logic [NUM_CH-1:0]        axis_rx_valid;
  logic [NUM_CH-1:0]        axis_rx_sop;
  logic [NUM_CH-1:0]        axis_rx_eop;
  logic [NUM_CH*HDR_W-1:0]  axis_rx_hdr;
  logic [NUM_CH*DATA_W-1:0] axis_rx_data;
  logic [3:0]               fifo_level;
  logic                     overflow_err;
  logic                     proto_err;

  beat_t exp_q[$];
  beat_t mon_act;
  beat_t mon_exp;
  int    checks = 0;
  int    errors = 0;
  int    pops   = 0;

  pcie_rx_avst_axis_bridge_ml #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .HDR_W(HDR_W),
    .READY_LATENCY(3), .DEPTH(8), .COMPACT(1)
  ) dut (
    .avl_clk(clk), .avl_rst(rst),
    .avl_rx_valid(avl_rx_valid), .avl_rx_sop(avl_rx_sop), .avl_rx_eop(avl_rx_eop),
    .avl_rx_hdr(avl_rx_hdr), .avl_rx_data(avl_rx_data), .avl_rx_ready(avl_rx_ready),
    .axis_rx_tvalid(axis_rx_tvalid), .axis_rx_tready(axis_rx_tready),
    .axis_rx_valid(axis_rx_valid), .axis_rx_sop(axis_rx_sop), .axis_rx_eop(axis_rx_eop),
    .axis_rx_hdr(axis_rx_hdr), .axis_rx_data(axis_rx_data),
    .fifo_level(fifo_level), .overflow_err(overflow_err), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] s, input logic [1:0] e,
                       input logic [15:0] h0, input logic [15:0] h1,
                       input logic [31:0] d0, input logic [31:0] d1);
    avl_rx_valid = v;
    avl_rx_sop   = s;
    avl_rx_eop   = e;
    avl_rx_hdr   = {h1, h0};
    avl_rx_data  = {d1, d0};
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 32'h0, 32'h0);
  endtask

  task automatic expect_beat(input logic [1:0] v, input logic [1:0] s, input logic [1:0] e,
                             input logic [15:0] h0, input logic [15:0] h1,
                             input logic [31:0] d0, input logic [31:0] d1);
    beat_t b;
    b = {v, s, e, h1, h0, d1, d0};
    exp_q.push_back(b);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every handshake pops the next expected beat and compares the whole presented beat.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && axis_rx_tvalid && axis_rx_tready) begin
        mon_act = {axis_rx_valid, axis_rx_sop, axis_rx_eop, axis_rx_hdr, axis_rx_data};
        pops++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected actual=%0h required=none", mon_act);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_act !== mon_exp) begin
            errors++;
            $display("FAIL beat_%0d actual=%0h required=%0h", pops, mon_act, mon_exp);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] hv;
    rst = 1'b1;
    axis_rx_tready = 1'b0;
    idle();
    repeat (3) tick();
    chk("rst_ready", avl_rx_ready, 1'b0);
    chk("rst_tvalid", axis_rx_tvalid, 1'b0);
    chk("rst_level", fifo_level, 4'd0);
    chk("rst_ovf", overflow_err, 1'b0);
    chk("rst_proto", proto_err, 1'b0);

    rst = 1'b0;
    tick();
    chk("ready_after_rst", avl_rx_ready, 1'b1);

    // 1: single beat, visible the next cycle
    drive(2'b01, 2'b01, 2'b01, 16'h00A5, 16'h0000, 32'hD00000A5, 32'h0);
    expect_beat(2'b01, 2'b01, 2'b01, 16'h00A5, 16'h0000, 32'hD00000A5, 32'h0);
    tick();
    idle();
    chk("t1_tvalid", axis_rx_tvalid, 1'b1);
    chk("t1_level", fifo_level, 4'd1);
    axis_rx_tready = 1'b1;
    tick();
    axis_rx_tready = 1'b0;
    chk("t1_drain_level", fifo_level, 4'd0);
    chk("t1_drain_tvalid", axis_rx_tvalid, 1'b0);

    // 2: fill with tready low; ready drops once occupancy reaches 4
    for (int i = 0; i < 8; i++) begin
      hv = 16'h0010 + 16'(i);
      drive(2'b01, 2'b01, 2'b01, hv, 16'h0000, {16'hC0DE, hv}, 32'h0);
      expect_beat(2'b01, 2'b01, 2'b01, hv, 16'h0000, {16'hC0DE, hv}, 32'h0);
      tick();
      if (i == 2) chk("t2_ready_lvl3", avl_rx_ready, 1'b1);
      if (i == 3) chk("t2_ready_lvl4", avl_rx_ready, 1'b0);
    end
    idle();
    chk("t2_level_full", fifo_level, 4'd8);
    chk("t2_ovf", overflow_err, 1'b0);

    // 3: drop at full, then simultaneous read+write at full, then drain
    drive(2'b01, 2'b01, 2'b01, 16'h00EE, 16'h0000, 32'hEE, 32'h0);
    tick();
    idle();
    chk("t3_ovf", overflow_err, 1'b1);
    chk("t3_level_drop", fifo_level, 4'd8);
    axis_rx_tready = 1'b1;
    drive(2'b01, 2'b01, 2'b01, 16'h0050, 16'h0000, 32'h50, 32'h0);
    expect_beat(2'b01, 2'b01, 2'b01, 16'h0050, 16'h0000, 32'h50, 32'h0);
    tick();
    idle();
    chk("t3_level_rw_full", fifo_level, 4'd8);
    repeat (9) tick();
    axis_rx_tready = 1'b0;
    chk("t3_level_drained", fifo_level, 4'd0);
    chk("t3_tvalid_drained", axis_rx_tvalid, 1'b0);
    chk("t3_ready_back", avl_rx_ready, 1'b1);
    chk("t3_pops", 64'(pops), 64'd10);

    // 4: compaction of ch1 into slot 0, then a full two-channel beat
    drive(2'b10, 2'b10, 2'b10, 16'h0077, 16'h003C, 32'h77, 32'h1234);
    expect_beat(2'b01, 2'b01, 2'b01, 16'h003C, 16'h0000, 32'h1234, 32'h0);
    tick();
    idle();
    chk("t4_tvalid", axis_rx_tvalid, 1'b1);
    drive(2'b11, 2'b11, 2'b11, 16'h0011, 16'h0022, 32'h11, 32'h22);
    expect_beat(2'b11, 2'b11, 2'b11, 16'h0011, 16'h0022, 32'h11, 32'h22);
    axis_rx_tready = 1'b1;
    tick();
    idle();
    tick();
    axis_rx_tready = 1'b0;
    chk("t4_level", fifo_level, 4'd0);

    // 5: protocol violations on ch0 (double sop) and ch1 (eop while idle)
    drive(2'b01, 2'b01, 2'b00, 16'h0101, 16'h0000, 32'h101, 32'h0);
    expect_beat(2'b01, 2'b01, 2'b00, 16'h0101, 16'h0000, 32'h101, 32'h0);
    tick();
    chk("t5_proto_ok", proto_err, 1'b0);
    drive(2'b01, 2'b01, 2'b00, 16'h0202, 16'h0000, 32'h202, 32'h0);
    expect_beat(2'b01, 2'b01, 2'b00, 16'h0202, 16'h0000, 32'h202, 32'h0);
    tick();
    idle();
    chk("t5_proto_sop", proto_err, 1'b1);
    drive(2'b10, 2'b00, 2'b10, 16'h0000, 16'h0044, 32'h0, 32'h4400);
    expect_beat(2'b01, 2'b00, 2'b01, 16'h0044, 16'h0000, 32'h4400, 32'h0);
    tick();
    idle();
    chk("t5_proto_sticky", proto_err, 1'b1);
    axis_rx_tready = 1'b1;
    repeat (3) tick();
    axis_rx_tready = 1'b0;
    chk("t5_level", fifo_level, 4'd0);
    chk("t5_ovf_sticky", overflow_err, 1'b1);

    // 6: reset with buffered beats discards them
    for (int i = 0; i < 5; i++) begin
      hv = 16'h0060 + 16'(i);
      drive(2'b01, 2'b01, 2'b01, hv, 16'h0000, {16'h0BAD, hv}, 32'h0);
      tick();
    end
    idle();
    chk("t6_level5", fifo_level, 4'd5);
    rst = 1'b1;
    tick();
    chk("t6_rst_tvalid", axis_rx_tvalid, 1'b0);
    chk("t6_rst_level", fifo_level, 4'd0);
    chk("t6_rst_ovf", overflow_err, 1'b0);
    chk("t6_rst_proto", proto_err, 1'b0);
    chk("t6_rst_ready", avl_rx_ready, 1'b0);
    rst = 1'b0;
    tick();
    chk("t6_ready", avl_rx_ready, 1'b1);
    drive(2'b01, 2'b01, 2'b01, 16'h0099, 16'h0000, 32'h99, 32'h0);
    expect_beat(2'b01, 2'b01, 2'b01, 16'h0099, 16'h0000, 32'h99, 32'h0);
    tick();
    idle();
    chk("t6_tvalid", axis_rx_tvalid, 1'b1);
    chk("t6_level1", fifo_level, 4'd1);
    axis_rx_tready = 1'b1;
    tick();
    axis_rx_tready = 1'b0;
    chk("t6_level0", fifo_level, 4'd0);
    chk("t6_proto_clean", proto_err, 1'b0);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("pop_total", 64'(pops), 64'd16);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
